timer_arm_host: RTL and testbench

Bus initiator that programs the memory-mapped machine timer (mtime/mtimecmp at BaseAddr+0/4/8/12) over the single-outstanding req/rvalid data bus. It accepts an "arm" command carrying a 64-bit delta or absolute deadline. It reads mtime with a rollover-safe hi/lo/hi sequence, computes the deadline, and writes mtimecmp in glitch-free order. It sits between a small controller (or test sequencer) and the timer, replacing software arm routines.

---
 rtl/timer_arm_host_if.sv | 32 +++
 rtl/timer_arm_host.sv | 237 +++++++++++++++++++++++
 tb/tb_timer_arm_host.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_arm_host_if.sv
// ============================================================================
// Module      : timer_arm_host_if
// Description : Single-outstanding req/rvalid data bus used by timer_arm_host.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_arm_host_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                      req;
    logic [ADDRESS_WIDTH-1:0]  addr;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      rvalid;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      err;

    modport master (
        output req, addr, we, be, wdata,
        input  rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output rvalid, rdata, err
    );
endinterface

`default_nettype wire

// File: rtl/timer_arm_host.sv
// ============================================================================
// Module      : timer_arm_host
// Description : Arms the machine timer: rollover-safe mtime read, deadline
//               computation and glitch-free mtimecmp write sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_arm_host #(
    parameter int                       ADDRESS_WIDTH  = 32,
    parameter int                       DATA_WIDTH     = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR      = 'h0003_0000,
    parameter int                       TIMEOUT_CYCLES = 16,
    parameter int                       MAX_RETRIES    = 3
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        arm_valid_i,
    output logic             arm_ready_o,
    input  wire logic        arm_abs_i,
    input  wire logic [63:0] arm_value_i,
    output logic             done_o,
    output logic             err_o,
    output logic [63:0]      target_o,
    timer_arm_host_if.master host
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_HI1,
        ST_RD_LO,
        ST_RD_HI2,
        ST_WR_CMP_LO_MAX,
        ST_WR_CMP_HI,
        ST_WR_CMP_LO,
        ST_DONE,
        ST_ABORT
    } state_e;

    localparam int c_retry_w = $clog2(MAX_RETRIES + 1);
    localparam int c_tmo_w   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_retry_w-1:0] c_max_retries = c_retry_w'(MAX_RETRIES);
    localparam logic [c_tmo_w-1:0]   c_tmo_last    = c_tmo_w'(TIMEOUT_CYCLES - 1);

    state_e                    state_q, state_d;
    logic                      wait_q, wait_d;
    logic [63:0]               value_q, value_d;
    logic [DATA_WIDTH-1:0]     hi1_q, hi1_d;
    logic [DATA_WIDTH-1:0]     lo_q, lo_d;
    logic [63:0]               target_q, target_d;
    logic [c_retry_w-1:0]      retry_q, retry_d;
    logic [c_tmo_w-1:0]        tmo_q, tmo_d;
    logic                      req_q, req_d;
    logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic                      we_q, we_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      ready_q, ready_d;
    logic                      start_access;
    logic [c_retry_w-1:0]      retry_inc;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        value_d      = value_q;
        hi1_d        = hi1_q;
        lo_d         = lo_q;
        target_d     = target_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        req_d        = 1'b0;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        start_access = 1'b0;
        retry_inc    = retry_q + c_retry_w'(1);

        case (state_q)
            ST_IDLE: begin
                if (arm_valid_i) begin
                    value_d      = arm_value_i;
                    retry_d      = '0;
                    start_access = 1'b1;
                    if (arm_abs_i) begin
                        target_d = arm_value_i;
                        state_d  = ST_WR_CMP_LO_MAX;
                    end else begin
                        state_d  = ST_RD_HI1;
                    end
                end
            end
            ST_DONE, ST_ABORT: state_d = ST_IDLE;
            default: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                    tmo_d  = '0;
                end else if (host.rvalid) begin
                    wait_d = 1'b0;
                    if (host.err) begin
                        state_d = ST_ABORT;
                    end else begin
                        case (state_q)
                            ST_RD_HI1: begin
                                hi1_d        = host.rdata;
                                state_d      = ST_RD_LO;
                                start_access = 1'b1;
                            end
                            ST_RD_LO: begin
                                lo_d         = host.rdata;
                                state_d      = ST_RD_HI2;
                                start_access = 1'b1;
                            end
                            ST_RD_HI2: begin
                                // A changed high word means lo may belong to either epoch.
                                if (host.rdata == hi1_q) begin
                                    target_d     = {hi1_q, lo_q} + value_q;
                                    state_d      = ST_WR_CMP_LO_MAX;
                                    start_access = 1'b1;
                                end else begin
                                    retry_d = retry_inc;
                                    if (retry_inc == c_max_retries) begin
                                        state_d = ST_ABORT;
                                    end else begin
                                        state_d      = ST_RD_HI1;
                                        start_access = 1'b1;
                                    end
                                end
                            end
                            ST_WR_CMP_LO_MAX: begin
                                state_d      = ST_WR_CMP_HI;
                                start_access = 1'b1;
                            end
                            ST_WR_CMP_HI: begin
                                state_d      = ST_WR_CMP_LO;
                                start_access = 1'b1;
                            end
                            ST_WR_CMP_LO: state_d = ST_DONE;
                            default:      state_d = ST_ABORT;
                        endcase
                    end
                end else if (tmo_q == c_tmo_last) begin
                    wait_d  = 1'b0;
                    state_d = ST_ABORT;
                end else begin
                    tmo_d = tmo_q + c_tmo_w'(1);
                end
            end
        endcase

        if (start_access) begin
            req_d = 1'b1;
            tmo_d = '0;
            case (state_d)
                ST_RD_HI1, ST_RD_HI2: begin
                    addr_d  = BASE_ADDR + ADDRESS_WIDTH'(4);
                    we_d    = 1'b0;
                    wdata_d = '0;
                end
                ST_RD_LO: begin
                    addr_d  = BASE_ADDR;
                    we_d    = 1'b0;
                    wdata_d = '0;
                end
                ST_WR_CMP_LO_MAX: begin
                    addr_d  = BASE_ADDR + ADDRESS_WIDTH'(8);
                    we_d    = 1'b1;
                    wdata_d = '1;
                end
                ST_WR_CMP_HI: begin
                    addr_d  = BASE_ADDR + ADDRESS_WIDTH'(12);
                    we_d    = 1'b1;
                    wdata_d = target_d[63:32];
                end
                ST_WR_CMP_LO: begin
                    addr_d  = BASE_ADDR + ADDRESS_WIDTH'(8);
                    we_d    = 1'b1;
                    wdata_d = target_d[31:0];
                end
                default: req_d = 1'b0;
            endcase
        end

        done_d  = (state_d == ST_DONE) || (state_d == ST_ABORT);
        err_d   = (state_d == ST_ABORT);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            wait_q   <= 1'b0;
            value_q  <= '0;
            hi1_q    <= '0;
            lo_q     <= '0;
            target_q <= '0;
            retry_q  <= '0;
            tmo_q    <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            value_q  <= value_d;
            hi1_q    <= hi1_d;
            lo_q     <= lo_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            tmo_q    <= tmo_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign arm_ready_o = ready_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign target_o    = target_q;
    assign host.req    = req_q;
    assign host.addr   = addr_q;
    assign host.we     = we_q;
    assign host.be     = '1;
    assign host.wdata  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_arm_host.sv
// ============================================================================
// Module      : tb_timer_arm_host
// Description : Scoreboard bench for timer_arm_host with a scripted responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_arm_host;

    localparam logic [31:0] c_base = 32'h0003_0000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm_valid;
    logic        arm_ready;
    logic        arm_abs;
    logic [63:0] arm_value;
    logic        done;
    logic        err;
    logic [63:0] target;

    int   n_vec    = 0;
    int   n_miscmp = 0;
    int   cyc      = 0;

    acc_t        exp_q[$];
    logic [31:0] rd_q[$];
    logic        resp_hold   = 1'b0;
    logic        resp_err_hi = 1'b0;

    timer_arm_host_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    timer_arm_host #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .BASE_ADDR     (c_base),
        .TIMEOUT_CYCLES(16),
        .MAX_RETRIES   (3)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .arm_valid_i(arm_valid),
        .arm_ready_o(arm_ready),
        .arm_abs_i  (arm_abs),
        .arm_value_i(arm_value),
        .done_o     (done),
        .err_o      (err),
        .target_o   (target),
        .host       (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_rd(input logic [31:0] off);
        acc_t a;
        a.we = 1'b0; a.addr = c_base + off; a.wdata = 32'h0;
        exp_q.push_back(a);
    endtask

    task automatic exp_wr(input logic [31:0] off, input logic [31:0] data);
        acc_t a;
        a.we = 1'b1; a.addr = c_base + off; a.wdata = data;
        exp_q.push_back(a);
    endtask

    task automatic exp_rel_reads(input logic [31:0] hi1, input logic [31:0] lo, input logic [31:0] hi2);
        exp_rd(32'd4); exp_rd(32'd0); exp_rd(32'd4);
        rd_q.push_back(hi1); rd_q.push_back(lo); rd_q.push_back(hi2);
    endtask

    task automatic exp_writes(input logic [63:0] tgt);
        exp_wr(32'd8, 32'hFFFF_FFFF);
        exp_wr(32'd12, tgt[63:32]);
        exp_wr(32'd8, tgt[31:0]);
    endtask

    // Responder: one-cycle latency; checks every request against the scoreboard.
    initial begin
        logic        pend;
        logic [31:0] pend_data;
        logic        pend_err;
        acc_t        a;
        pend = 1'b0; pend_data = '0; pend_err = 1'b0;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.rvalid = 1'b0; bus.err = 1'b0;
            if (pend) begin
                bus.rvalid = 1'b1; bus.rdata = pend_data; bus.err = pend_err;
                pend = 1'b0;
            end
            if (bus.req === 1'b1) begin
                chk("acc_be", {60'h0, bus.be}, 64'hF);
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", {31'h0, bus.addr}, 64'h0);
                    pend_data = '0;
                end else begin
                    a = exp_q.pop_front();
                    chk("acc_we", {63'h0, bus.we}, {63'h0, a.we});
                    chk("acc_addr", {32'h0, bus.addr}, {32'h0, a.addr});
                    if (a.we) chk("acc_wdata", {32'h0, bus.wdata}, {32'h0, a.wdata});
                    pend_data = (!bus.we && rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
                end
                pend_err = resp_err_hi && bus.we && (bus.addr == c_base + 32'd12);
                pend = !resp_hold;
            end
        end
    end

    task automatic run_arm(input string tag, input logic abs, input logic [63:0] val,
                           input logic exp_err, input logic [63:0] exp_tgt, input int exp_lat);
        int t0;
        int k;
        @(posedge clk); #1;
        chk({tag, "_ready"}, {63'h0, arm_ready}, 64'h1);
        arm_valid = 1'b1; arm_abs = abs; arm_value = val; t0 = cyc;
        @(posedge clk); #1;
        arm_valid = 1'b0; arm_abs = ~abs; arm_value = 64'hDEAD_BEEF_0BAD_F00D;
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (done !== 1'b1) begin
            chk({tag, "_done_timeout"}, 64'h0, 64'h1);
        end else begin
            chk({tag, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
            chk({tag, "_err"}, {63'h0, err}, {63'h0, exp_err});
            chk({tag, "_target"}, target, exp_tgt);
        end
        chk({tag, "_acc_left"}, 64'(exp_q.size()), 64'h0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {63'h0, done}, 64'h0);
        chk({tag, "_ready_after"}, {63'h0, arm_ready}, 64'h1);
        exp_q.delete();
        rd_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; arm_valid = 1'b0; arm_abs = 1'b0; arm_value = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'h0, arm_ready}, 64'h1);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_err", {63'h0, err}, 64'h0);
        chk("rst_req", {63'h0, bus.req}, 64'h0);
        chk("rst_addr", {32'h0, bus.addr}, 64'h0);
        chk("rst_target", target, 64'h0);
        rst = 1'b0;

        // Relative arm, no rollover
        exp_rel_reads(32'h1, 32'h10, 32'h1);
        exp_writes(64'h1_0000_0110);
        run_arm("rel", 1'b0, 64'h100, 1'b0, 64'h1_0000_0110, 13);

        // Rollover between hi reads, clean second attempt
        exp_rel_reads(32'h0, 32'hFFFF_FFFF, 32'h1);
        exp_rel_reads(32'h1, 32'h5, 32'h1);
        exp_writes(64'h1_0000_000A);
        run_arm("rollover", 1'b0, 64'h5, 1'b0, 64'h1_0000_000A, 19);

        // Persistent mismatch: abort after three attempts, target untouched
        for (int i = 0; i < 3; i++) exp_rel_reads(32'h0, 32'h0, 32'h1);
        run_arm("persist", 1'b0, 64'h7, 1'b1, 64'h1_0000_000A, 19);

        // Absolute arm
        exp_writes(64'hFFFF_FFFF_FFFF_FFFF);
        run_arm("abs", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 7);

        // Withheld response: abort TIMEOUT_CYCLES after the wait begins
        resp_hold = 1'b1;
        exp_rd(32'd4);
        run_arm("timeout", 1'b0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 18);
        resp_hold = 1'b0;

        // Error on the high compare write: no low write follows
        resp_err_hi = 1'b1;
        exp_wr(32'd8, 32'hFFFF_FFFF);
        exp_wr(32'd12, 32'h1234_5678);
        run_arm("bus_err", 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h1234_5678_9ABC_DEF0, 5);
        resp_err_hi = 1'b0;

        // Reset during RD_LO; the responder's reply then lands as a stale rvalid
        exp_rel_reads(32'h2, 32'h3, 32'h2);
        exp_q.pop_back();
        @(posedge clk); #1;
        arm_valid = 1'b1; arm_abs = 1'b0; arm_value = 64'h9;
        @(posedge clk); #1;
        arm_valid = 1'b0;
        k = 0;
        while (!(bus.req === 1'b1 && bus.addr == c_base) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst_mid_reached_lo", {63'h0, (bus.req === 1'b1 && bus.addr == c_base)}, 64'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_ready", {63'h0, arm_ready}, 64'h1);
        chk("rst_mid_done", {63'h0, done}, 64'h0);
        chk("rst_mid_err", {63'h0, err}, 64'h0);
        chk("rst_mid_req", {63'h0, bus.req}, 64'h0);
        chk("rst_mid_we", {63'h0, bus.we}, 64'h0);
        chk("rst_mid_addr", {32'h0, bus.addr}, 64'h0);
        chk("rst_mid_wdata", {32'h0, bus.wdata}, 64'h0);
        chk("rst_mid_target", target, 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stale_ready", {63'h0, arm_ready}, 64'h1);
            chk("stale_req", {63'h0, bus.req}, 64'h0);
            chk("stale_done", {63'h0, done}, 64'h0);
        end
        chk("rst_mid_acc_left", 64'(exp_q.size()), 64'h0);
        exp_q.delete();
        rd_q.delete();

        // Relative arm with 64-bit wrap-around
        exp_rel_reads(32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        exp_writes(64'h10);
        run_arm("wrap", 1'b0, 64'h20, 1'b0, 64'h10, 13);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

`default_nettype wire
